// File: rtl/alu_serial_deser.sv
// Serial-input deserializer for the mtm ALU family.
// Collects framed bytes from sin into operands B and A, then checks the
// command frame (framing, frame count, CRC4, opcode) and emits one record.
//
// state      | meaning
// -----------+--------------------------------------------------------
// S_IDLE     | line idle, waiting for a start bit; runs inter-frame timeout
// S_TYPE     | sampling the frame type bit (0 data, 1 command)
// S_DATA     | sampling 8 payload bits, MSB first
// S_STOP     | sampling the stop bit; accepts the frame or flags framing error
// S_ERR_WAIT | after a framing error, waiting for the line to return high
module alu_serial_deser #(
    parameter int W         = 32,
    parameter int TIMEOUT   = 64,
    parameter bit CHECK_CRC = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sin,
    output logic         out_valid,
    output logic [W-1:0] out_a,
    output logic [W-1:0] out_b,
    output logic [2:0]   out_op,
    output logic [3:0]   out_err
);

    localparam int N_BYTES = 2 * W / 8;
    localparam int CW      = $clog2(N_BYTES + 2);
    localparam int TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TYPE,
        S_DATA,
        S_STOP,
        S_ERR_WAIT
    } state_t;

    state_t         state_q,     state_d;
    logic [2:0]     bit_cnt_q,   bit_cnt_d;
    logic           type_q,      type_d;
    logic [7:0]     byte_q,      byte_d;
    logic [2*W-1:0] data_q,      data_d;
    logic [CW-1:0]  byte_cnt_q,  byte_cnt_d;
    logic [TW-1:0]  tmo_q,       tmo_d;
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   out_a_q,     out_a_d;
    logic [W-1:0]   out_b_q,     out_b_d;
    logic [2:0]     out_op_q,    out_op_d;
    logic [3:0]     out_err_q,   out_err_d;

    logic [3:0]     crc_calc;
    logic [3:0]     cmd_err;
    logic [2:0]     cmd_op;

    // CRC4, poly x^4+x+1, init 0, serial MSB-first over the whole stream.
    function automatic logic [3:0] crc4(input logic [2*W+3:0] s);
        logic [3:0] c;
        logic       fb;
        c = 4'b0000;
        for (int i = 2*W+3; i >= 0; i--) begin
            fb = c[3] ^ s[i];
            c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
        end
        return c;
    endfunction

    assign cmd_op   = byte_q[6:4];
    assign crc_calc = crc4({data_q, 1'b1, cmd_op});

    // Command evaluation with priority frame count > CRC > opcode.
    always_comb begin
        cmd_err = 4'b0000;
        if (byte_cnt_q != CW'(N_BYTES)) begin
            cmd_err = 4'b0100;
        end else if (CHECK_CRC && (crc_calc != byte_q[3:0])) begin
            cmd_err = 4'b0010;
        end else if (!(cmd_op inside {3'b000, 3'b001, 3'b100, 3'b101})) begin
            cmd_err = 4'b0001;
        end
    end

    // Next-state logic: frame receiver, byte assembly, timeout and record update.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        type_d      = type_q;
        byte_d      = byte_q;
        data_d      = data_q;
        byte_cnt_d  = byte_cnt_q;
        tmo_d       = tmo_q;
        out_valid_d = 1'b0;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_op_d    = out_op_q;
        out_err_d   = out_err_q;

        case (state_q)
            S_IDLE: begin
                if (!sin) begin
                    state_d = S_TYPE;
                    tmo_d   = '0;
                end else if ((TIMEOUT != 0) && (byte_cnt_q != '0)) begin
                    if (tmo_q == TW'(TIMEOUT - 1)) begin
                        out_valid_d = 1'b1;
                        out_err_d   = 4'b1000;
                        out_a_d     = '0;
                        out_b_d     = '0;
                        out_op_d    = '0;
                        byte_cnt_d  = '0;
                        tmo_d       = '0;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
            end
            S_TYPE: begin
                type_d    = sin;
                bit_cnt_d = '0;
                state_d   = S_DATA;
            end
            S_DATA: begin
                byte_d    = {byte_q[6:0], sin};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (sin) begin
                    state_d = S_IDLE;
                    if (!type_q) begin
                        data_d = {data_q[2*W-9:0], byte_q};
                        if (byte_cnt_q != CW'(N_BYTES + 1)) begin
                            byte_cnt_d = byte_cnt_q + CW'(1);
                        end
                    end else begin
                        out_valid_d = 1'b1;
                        out_err_d   = cmd_err;
                        byte_cnt_d  = '0;
                        if (cmd_err == 4'b0000) begin
                            out_b_d  = data_q[2*W-1:W];
                            out_a_d  = data_q[W-1:0];
                            out_op_d = cmd_op;
                        end else begin
                            out_b_d  = '0;
                            out_a_d  = '0;
                            out_op_d = '0;
                        end
                    end
                end else begin
                    state_d     = S_ERR_WAIT;
                    out_valid_d = 1'b1;
                    out_err_d   = 4'b0100;
                    out_a_d     = '0;
                    out_b_d     = '0;
                    out_op_d    = '0;
                    byte_cnt_d  = '0;
                end
            end
            S_ERR_WAIT: begin
                if (sin) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset discards any partial transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            type_q      <= 1'b0;
            byte_q      <= '0;
            data_q      <= '0;
            byte_cnt_q  <= '0;
            tmo_q       <= '0;
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_op_q    <= '0;
            out_err_q   <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            type_q      <= type_d;
            byte_q      <= byte_d;
            data_q      <= data_d;
            byte_cnt_q  <= byte_cnt_d;
            tmo_q       <= tmo_d;
            out_valid_q <= out_valid_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_op_q    <= out_op_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_op    = out_op_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_alu_serial_deser.sv
// Bench for alu_serial_deser: four instances (W=32 with CRC and timeout,
// W=32 without CRC or timeout, W=8, W=64), a serial frame driver and a
// per-instance queue of expected records checked whenever out_valid pulses.
module tb_alu_serial_deser;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [2:0]  op;
        logic [3:0]  err;
        longint      cyc;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  sin_v;
    logic [3:0]  ov;
    logic [31:0] a0, b0, a1, b1;
    logic [7:0]  a2, b2;
    logic [63:0] a3, b3;
    logic [2:0]  op0, op1, op2, op3;
    logic [3:0]  e0, e1, e2, e3;

    int     n_tests = 0;
    int     n_fail  = 0;
    longint cyc     = 0;
    longint stop_cyc;
    rec_t   q0[$], q1[$], q2[$], q3[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_serial_deser #(.W(32), .TIMEOUT(64), .CHECK_CRC(1'b1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .sin(sin_v[0]), .out_valid(ov[0]),
        .out_a(a0), .out_b(b0), .out_op(op0), .out_err(e0));
    alu_serial_deser #(.W(32), .TIMEOUT(0), .CHECK_CRC(1'b0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .sin(sin_v[1]), .out_valid(ov[1]),
        .out_a(a1), .out_b(b1), .out_op(op1), .out_err(e1));
    alu_serial_deser #(.W(8), .TIMEOUT(64), .CHECK_CRC(1'b1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .sin(sin_v[2]), .out_valid(ov[2]),
        .out_a(a2), .out_b(b2), .out_op(op2), .out_err(e2));
    alu_serial_deser #(.W(64), .TIMEOUT(64), .CHECK_CRC(1'b1)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .sin(sin_v[3]), .out_valid(ov[3]),
        .out_a(a3), .out_b(b3), .out_op(op3), .out_err(e3));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference CRC as polynomial long division of {B,A,1,op}*x^4 by x^4+x+1.
    function automatic logic [3:0] crc_model(input int w, input logic [63:0] b,
                                             input logic [63:0] a, input logic [2:0] op);
        logic [4:0] r;
        logic       s[$];
        r = 5'b0;
        for (int k = w - 1; k >= 0; k--) s.push_back(b[k]);
        for (int k = w - 1; k >= 0; k--) s.push_back(a[k]);
        s.push_back(1'b1);
        for (int k = 2; k >= 0; k--) s.push_back(op[k]);
        for (int k = 0; k < 4; k++) s.push_back(1'b0);
        foreach (s[i]) begin
            r = {r[3:0], s[i]};
            if (r[4]) r = r ^ 5'b10011;
        end
        return r[3:0];
    endfunction

    task automatic push_exp(input int d, input logic [63:0] a, input logic [63:0] b,
                            input logic [2:0] op, input logic [3:0] err, input longint c);
        rec_t r;
        r.a = a; r.b = b; r.op = op; r.err = err; r.cyc = c;
        case (d)
            0: q0.push_back(r);
            1: q1.push_back(r);
            2: q2.push_back(r);
            default: q3.push_back(r);
        endcase
    endtask

    task automatic check_out(input int d, input logic [63:0] a, input logic [63:0] b,
                             input logic [2:0] op, input logic [3:0] err);
        rec_t r;
        int   sz;
        case (d)
            0: sz = q0.size();
            1: sz = q1.size();
            2: sz = q2.size();
            default: sz = q3.size();
        endcase
        chk($sformatf("d%0d_expected_pending", d), 64'(sz > 0), 64'd1);
        if (sz > 0) begin
            case (d)
                0: r = q0.pop_front();
                1: r = q1.pop_front();
                2: r = q2.pop_front();
                default: r = q3.pop_front();
            endcase
            chk($sformatf("d%0d_err", d), 64'(err), 64'(r.err));
            chk($sformatf("d%0d_a", d), a, r.a);
            chk($sformatf("d%0d_b", d), b, r.b);
            chk($sformatf("d%0d_op", d), 64'(op), 64'(r.op));
            if (r.cyc >= 0) chk($sformatf("d%0d_latency", d), 64'(cyc), 64'(r.cyc));
        end
    endtask

    always @(negedge clk) if (ov[0]) check_out(0, {32'b0, a0}, {32'b0, b0}, op0, e0);
    always @(negedge clk) if (ov[1]) check_out(1, {32'b0, a1}, {32'b0, b1}, op1, e1);
    always @(negedge clk) if (ov[2]) check_out(2, {56'b0, a2}, {56'b0, b2}, op2, e2);
    always @(negedge clk) if (ov[3]) check_out(3, a3, b3, op3, e3);

    task automatic send_frame(input int d, input logic typ, input logic [7:0] pay, input logic stop);
        logic [10:0] f;
        f = {1'b0, typ, pay, stop};
        for (int i = 10; i >= 0; i--) begin
            @(negedge clk);
            sin_v[d] = f[i];
            if (i == 0) stop_cyc = cyc + 1;
        end
    endtask

    task automatic idle(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sin_v[d] = 1'b1;
        end
    endtask

    task automatic send_txn(input int d, input int w, input logic [63:0] b, input logic [63:0] a,
                            input logic [2:0] op, input logic [3:0] crc_x,
                            input int n_data, input bit with_cmd);
        logic [127:0] ba;
        int           nb;
        nb = 2 * w / 8;
        ba = ({64'b0, b} << w) | {64'b0, a};
        for (int i = 0; i < n_data && i < nb; i++)
            send_frame(d, 1'b0, ba[8*(nb-1-i) +: 8], 1'b1);
        if (with_cmd)
            send_frame(d, 1'b1, {1'b0, op, crc_model(w, b, a, op) ^ crc_x}, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        sin_v = 4'hF;
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(ov[0]), 64'd0);
        chk("rst_a", 64'(a0), 64'd0);
        chk("rst_b", 64'(b0), 64'd0);
        chk("rst_op", 64'(op0), 64'd0);
        chk("rst_err", 64'(e0), 64'd0);
        rst_n = 1'b1;
        idle(0, 3);

        // basic ADD, then back-to-back short transaction and recovery
        send_txn(0, 32, 64'd3, 64'd2, OP_ADD, 4'd0, 8, 1'b1);
        push_exp(0, 64'd2, 64'd3, OP_ADD, 4'b0000, stop_cyc);
        send_txn(0, 32, 64'h11223344, 64'h55667788, OP_AND, 4'd0, 7, 1'b1);
        push_exp(0, 64'd0, 64'd0, 3'd0, 4'b0100, stop_cyc);
        send_txn(0, 32, 64'hDEADBEEF, 64'h12345678, OP_SUB, 4'd0, 8, 1'b1);
        push_exp(0, 64'h12345678, 64'hDEADBEEF, OP_SUB, 4'b0000, stop_cyc);
        idle(0, 2);

        // corrupted CRC, then illegal opcode
        send_txn(0, 32, 64'hCAFEF00D, 64'h0BADBEEF, OP_OR, 4'b0001, 8, 1'b1);
        push_exp(0, 64'd0, 64'd0, 3'd0, 4'b0010, stop_cyc);
        send_txn(0, 32, 64'd7, 64'd9, 3'b111, 4'd0, 8, 1'b1);
        push_exp(0, 64'd0, 64'd0, 3'd0, 4'b0001, stop_cyc);
        idle(0, 2);

        // inter-frame timeout, then a clean transaction
        send_txn(0, 32, 64'hA1B2C3D4, 64'h0, OP_ADD, 4'd0, 3, 1'b0);
        push_exp(0, 64'd0, 64'd0, 3'd0, 4'b1000, -1);
        idle(0, 70);
        send_txn(0, 32, 64'h00000100, 64'hFFFFFFFF, OP_ADD, 4'd0, 8, 1'b1);
        push_exp(0, 64'hFFFFFFFF, 64'h00000100, OP_ADD, 4'b0000, stop_cyc);

        // framing error in data frame 2, then recovery
        send_frame(0, 1'b0, 8'hAA, 1'b1);
        send_frame(0, 1'b0, 8'h55, 1'b0);
        push_exp(0, 64'd0, 64'd0, 3'd0, 4'b0100, stop_cyc);
        idle(0, 3);
        send_txn(0, 32, 64'h80000001, 64'h7FFFFFFE, OP_OR, 4'd0, 8, 1'b1);
        push_exp(0, 64'h7FFFFFFE, 64'h80000001, OP_OR, 4'b0000, stop_cyc);
        idle(0, 4);

        // reset in the middle of a command frame
        send_txn(0, 32, 64'h01020304, 64'h05060708, OP_ADD, 4'd0, 8, 1'b0);
        @(negedge clk); sin_v[0] = 1'b0;
        @(negedge clk); sin_v[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); sin_v[0] = 1'b0;
        end
        @(negedge clk);
        rst_n    = 1'b0;
        sin_v[0] = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_valid", 64'(ov[0]), 64'd0);
        chk("midrst_a", 64'(a0), 64'd0);
        chk("midrst_b", 64'(b0), 64'd0);
        chk("midrst_err", 64'(e0), 64'd0);
        rst_n = 1'b1;
        idle(0, 3);
        send_txn(0, 32, 64'd3, 64'd2, OP_ADD, 4'd0, 8, 1'b1);
        push_exp(0, 64'd2, 64'd3, OP_ADD, 4'b0000, stop_cyc);
        idle(0, 3);

        // CHECK_CRC=0 / TIMEOUT=0 instance
        send_txn(1, 32, 64'hCAFEF00D, 64'h0BADBEEF, OP_OR, 4'b0001, 8, 1'b1);
        push_exp(1, 64'h0BADBEEF, 64'hCAFEF00D, OP_OR, 4'b0000, stop_cyc);
        send_txn(1, 32, 64'h1, 64'h2, OP_ADD, 4'd0, 3, 1'b0);
        idle(1, 100);
        send_txn(1, 32, 64'h1, 64'h2, OP_ADD, 4'd0, 0, 1'b1);
        push_exp(1, 64'd0, 64'd0, 3'd0, 4'b0100, stop_cyc);
        idle(1, 3);

        // W=8 and W=64 instances
        send_txn(2, 8, 64'd3, 64'd2, OP_ADD, 4'd0, 2, 1'b1);
        push_exp(2, 64'd2, 64'd3, OP_ADD, 4'b0000, stop_cyc);
        send_txn(2, 8, 64'hF0, 64'h0F, OP_AND, 4'b1000, 2, 1'b1);
        push_exp(2, 64'd0, 64'd0, 3'd0, 4'b0010, stop_cyc);
        idle(2, 3);
        send_txn(3, 64, 64'd3, 64'd2, OP_ADD, 4'd0, 16, 1'b1);
        push_exp(3, 64'd2, 64'd3, OP_ADD, 4'b0000, stop_cyc);
        send_txn(3, 64, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, OP_SUB, 4'd0, 16, 1'b1);
        push_exp(3, 64'hFEDCBA9876543210, 64'h0123456789ABCDEF, OP_SUB, 4'b0000, stop_cyc);
        idle(3, 5);

        chk("q0_drained", 64'(q0.size()), 64'd0);
        chk("q1_drained", 64'(q1.size()), 64'd0);
        chk("q2_drained", 64'(q2.size()), 64'd0);
        chk("q3_drained", 64'(q3.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
